// File: rtl/ct_biu_csr_pkg.sv
// Shared constants for the BIU CSR request arbiter: FSM encoding, requester
// indices, datapath widths and the 2-way round-robin pick rule.
package ct_biu_csr_pkg;

    localparam int OP_W    = 16;
    localparam int WDATA_W = 64;
    localparam int RDATA_W = 128;
    localparam int CNT_W   = 16;

    localparam logic REQ_CP0 = 1'b0;
    localparam logic REQ_HAD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } csr_state_e;

    // On a tie the requester that was not served last wins.
    function automatic logic rr_pick(
        input logic req_cp0,
        input logic req_had,
        input logic last_grant
    );
        if (req_cp0 && req_had) begin
            return ~last_grant;
        end else if (req_had) begin
            return REQ_HAD;
        end else begin
            return REQ_CP0;
        end
    endfunction

endpackage

// File: rtl/ct_biu_csr_rr_arb2.sv
// Two-way round-robin pick between CP0 and HAD plus the last_grant register.
// last_grant resets to HAD so CP0 wins the first tie.
module ct_biu_csr_rr_arb2
    import ct_biu_csr_pkg::*;
(
    input  logic coreclk,
    input  logic cpurst_b,
    input  logic i_req_cp0,
    input  logic i_req_had,
    input  logic i_grant_en,
    output logic o_any_req,
    output logic o_grant_idx
);

    logic r_last_grant;

    assign o_any_req   = i_req_cp0 | i_req_had;
    assign o_grant_idx = rr_pick(i_req_cp0, i_req_had, r_last_grant);

    always_ff @(posedge coreclk) begin
        if (!cpurst_b) begin
            r_last_grant <= REQ_HAD;
        end else if (i_grant_en && o_any_req) begin
            r_last_grant <= o_grant_idx;
        end
    end

endmodule

// File: rtl/ct_biu_csr_req_arb.sv
// Sequences CP0/HAD CSR requests onto the single BIU CSR channel, one at a time.
// Define CT_BIU_CSR_TIMEOUT_EN to build the completion timeout, err outputs and sticky flag.
module ct_biu_csr_req_arb
    import ct_biu_csr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 coreclk,
    input  logic                 cpurst_b,
    input  logic                 cp0_biu_csr_req,
    input  logic [OP_W-1:0]      cp0_biu_csr_op,
    input  logic [WDATA_W-1:0]   cp0_biu_csr_wdata,
    output logic                 biu_cp0_csr_cmplt,
    output logic [RDATA_W-1:0]   biu_cp0_csr_rdata,
    output logic                 biu_cp0_csr_err,
    input  logic                 had_biu_csr_req,
    input  logic [OP_W-1:0]      had_biu_csr_op,
    input  logic [WDATA_W-1:0]   had_biu_csr_wdata,
    output logic                 biu_had_csr_cmplt,
    output logic [RDATA_W-1:0]   biu_had_csr_rdata,
    output logic                 biu_had_csr_err,
    output logic                 biu_csr_sel,
    output logic [OP_W-1:0]      biu_csr_op,
    output logic [WDATA_W-1:0]   biu_csr_wdata,
    input  logic                 biu_csr_cmplt,
    input  logic [RDATA_W-1:0]   biu_csr_rdata,
    output logic                 biu_csr_busy,
    output logic                 biu_csr_timeout_sticky,
    output logic [1:0]           o_dbg_state
);

    csr_state_e           r_state;
    logic                 r_grant;
    logic                 r_sel;
    logic                 r_busy;
    logic [OP_W-1:0]      r_op;
    logic [WDATA_W-1:0]   r_wdata;
    logic                 r_cp0_cmplt;
    logic                 r_had_cmplt;
    logic [RDATA_W-1:0]   r_cp0_rdata;
    logic [RDATA_W-1:0]   r_had_rdata;

    logic                 w_any_req;
    logic                 w_pick;
    logic                 w_grant_en;
    logic                 w_expire;
    logic                 w_finish;
    logic [RDATA_W-1:0]   w_rsp_rdata;

    assign w_grant_en = (r_state == ST_IDLE);

    ct_biu_csr_rr_arb2 u_rr_arb2 (
        .coreclk     (coreclk),
        .cpurst_b    (cpurst_b),
        .i_req_cp0   (cp0_biu_csr_req),
        .i_req_had   (had_biu_csr_req),
        .i_grant_en  (w_grant_en),
        .o_any_req   (w_any_req),
        .o_grant_idx (w_pick)
    );

    // A completion in the expiry cycle wins over the timeout.
    assign w_finish    = (r_state == ST_BUSY) && (biu_csr_cmplt || w_expire);
    assign w_rsp_rdata = biu_csr_cmplt ? biu_csr_rdata : '0;

    always_ff @(posedge coreclk) begin
        if (!cpurst_b) begin
            r_state     <= ST_IDLE;
            r_grant     <= REQ_HAD;
            r_sel       <= 1'b0;
            r_busy      <= 1'b0;
            r_op        <= '0;
            r_wdata     <= '0;
            r_cp0_cmplt <= 1'b0;
            r_had_cmplt <= 1'b0;
            r_cp0_rdata <= '0;
            r_had_rdata <= '0;
        end else begin
            r_cp0_cmplt <= 1'b0;
            r_had_cmplt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_BUSY;
                        r_grant <= w_pick;
                        r_sel   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_op    <= (w_pick == REQ_HAD) ? had_biu_csr_op : cp0_biu_csr_op;
                        r_wdata <= (w_pick == REQ_HAD) ? had_biu_csr_wdata : cp0_biu_csr_wdata;
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_sel   <= 1'b0;
                        if (r_grant == REQ_HAD) begin
                            r_had_cmplt <= 1'b1;
                            r_had_rdata <= w_rsp_rdata;
                        end else begin
                            r_cp0_cmplt <= 1'b1;
                            r_cp0_rdata <= w_rsp_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CT_BIU_CSR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_cp0_err;
    logic             r_had_err;
    logic             r_sticky;
    logic             w_timed_out;

    assign w_expire    = (r_state == ST_BUSY) && (r_cnt == TO_LAST);
    assign w_timed_out = w_expire && !biu_csr_cmplt;

    always_ff @(posedge coreclk) begin
        if (!cpurst_b) begin
            r_cnt     <= '0;
            r_cp0_err <= 1'b0;
            r_had_err <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_cnt <= (r_state == ST_BUSY) ? r_cnt + 1'b1 : '0;
            if (w_finish) begin
                if (r_grant == REQ_HAD) begin
                    r_had_err <= w_timed_out;
                end else begin
                    r_cp0_err <= w_timed_out;
                end
                if (w_timed_out) begin
                    r_sticky <= 1'b1;
                end
            end
        end
    end

    assign biu_cp0_csr_err        = r_cp0_err;
    assign biu_had_csr_err        = r_had_err;
    assign biu_csr_timeout_sticky = r_sticky;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_expire               = 1'b0;
    assign biu_cp0_csr_err        = 1'b0;
    assign biu_had_csr_err        = 1'b0;
    assign biu_csr_timeout_sticky = 1'b0;
`endif

    assign biu_csr_sel       = r_sel;
    assign biu_csr_op        = r_op;
    assign biu_csr_wdata     = r_wdata;
    assign biu_csr_busy      = r_busy;
    assign biu_cp0_csr_cmplt = r_cp0_cmplt;
    assign biu_cp0_csr_rdata = r_cp0_rdata;
    assign biu_had_csr_cmplt = r_had_cmplt;
    assign biu_had_csr_rdata = r_had_rdata;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_ct_biu_csr_req_arb.sv
// Directed plus randomized bench for ct_biu_csr_req_arb against a transaction-level model.
// Timeout scenarios are exercised when CT_BIU_CSR_TIMEOUT_EN is defined.
module tb_ct_biu_csr_req_arb;

    logic         coreclk;
    logic         cpurst_b;
    logic         cp0_biu_csr_req;
    logic [15:0]  cp0_biu_csr_op;
    logic [63:0]  cp0_biu_csr_wdata;
    logic         biu_cp0_csr_cmplt;
    logic [127:0] biu_cp0_csr_rdata;
    logic         biu_cp0_csr_err;
    logic         had_biu_csr_req;
    logic [15:0]  had_biu_csr_op;
    logic [63:0]  had_biu_csr_wdata;
    logic         biu_had_csr_cmplt;
    logic [127:0] biu_had_csr_rdata;
    logic         biu_had_csr_err;
    logic         biu_csr_sel;
    logic [15:0]  biu_csr_op;
    logic [63:0]  biu_csr_wdata;
    logic         biu_csr_cmplt;
    logic [127:0] biu_csr_rdata;
    logic         biu_csr_busy;
    logic         biu_csr_timeout_sticky;
    logic [1:0]   o_dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    ct_biu_csr_req_arb #(.TIMEOUT_CYCLES(8)) dut (
        .coreclk                (coreclk),
        .cpurst_b               (cpurst_b),
        .cp0_biu_csr_req        (cp0_biu_csr_req),
        .cp0_biu_csr_op         (cp0_biu_csr_op),
        .cp0_biu_csr_wdata      (cp0_biu_csr_wdata),
        .biu_cp0_csr_cmplt      (biu_cp0_csr_cmplt),
        .biu_cp0_csr_rdata      (biu_cp0_csr_rdata),
        .biu_cp0_csr_err        (biu_cp0_csr_err),
        .had_biu_csr_req        (had_biu_csr_req),
        .had_biu_csr_op         (had_biu_csr_op),
        .had_biu_csr_wdata      (had_biu_csr_wdata),
        .biu_had_csr_cmplt      (biu_had_csr_cmplt),
        .biu_had_csr_rdata      (biu_had_csr_rdata),
        .biu_had_csr_err        (biu_had_csr_err),
        .biu_csr_sel            (biu_csr_sel),
        .biu_csr_op             (biu_csr_op),
        .biu_csr_wdata          (biu_csr_wdata),
        .biu_csr_cmplt          (biu_csr_cmplt),
        .biu_csr_rdata          (biu_csr_rdata),
        .biu_csr_busy           (biu_csr_busy),
        .biu_csr_timeout_sticky (biu_csr_timeout_sticky),
        .o_dbg_state            (o_dbg_state)
    );

    // Clock and reset
    initial coreclk = 1'b0;
    always #5 coreclk = ~coreclk;

    // Step to just after the next rising edge: drive and sample point.
    task automatic tick();
        @(posedge coreclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_reset();
        cpurst_b        = 1'b0;
        cp0_biu_csr_req = 1'b0;
        had_biu_csr_req = 1'b0;
        biu_csr_cmplt   = 1'b0;
        biu_csr_rdata   = '0;
        tick();
        tick();
        cpurst_b = 1'b1;
    endtask

    task automatic chk_reset_values();
        chk("rst_sel",       128'(biu_csr_sel), 128'd0);
        chk("rst_op",        128'(biu_csr_op), 128'd0);
        chk("rst_wdata",     128'(biu_csr_wdata), 128'd0);
        chk("rst_busy",      128'(biu_csr_busy), 128'd0);
        chk("rst_sticky",    128'(biu_csr_timeout_sticky), 128'd0);
        chk("rst_cp0_cmplt", 128'(biu_cp0_csr_cmplt), 128'd0);
        chk("rst_had_cmplt", 128'(biu_had_csr_cmplt), 128'd0);
        chk("rst_cp0_rdata", biu_cp0_csr_rdata, 128'd0);
        chk("rst_had_rdata", biu_had_csr_rdata, 128'd0);
        chk("rst_cp0_err",   128'(biu_cp0_csr_err), 128'd0);
        chk("rst_had_err",   128'(biu_had_csr_err), 128'd0);
        chk("rst_state",     128'(o_dbg_state), 128'd0);
    endtask

    // Driver: raise one requester's level with its op/wdata.
    task automatic drive_req(input logic who, input logic [15:0] op, input logic [63:0] wd);
        if (who) begin
            had_biu_csr_req   = 1'b1;
            had_biu_csr_op    = op;
            had_biu_csr_wdata = wd;
        end else begin
            cp0_biu_csr_req   = 1'b1;
            cp0_biu_csr_op    = op;
            cp0_biu_csr_wdata = wd;
        end
    endtask

    // Reference model state: who was served last and each side's last returned rdata.
    logic         ref_last;
    logic [127:0] ref_rd [2];
    logic [15:0]  ref_op [2];
    logic [63:0]  ref_wd [2];
    logic         pend [2];

    initial begin
        logic         win;
        logic [127:0] rd;
        int           lat;
        int           sel_low;

        cp0_biu_csr_req = 1'b0; cp0_biu_csr_op = '0; cp0_biu_csr_wdata = '0;
        had_biu_csr_req = 1'b0; had_biu_csr_op = '0; had_biu_csr_wdata = '0;
        biu_csr_cmplt = 1'b0; biu_csr_rdata = '0;
        cpurst_b = 1'b0;

        // ---- Reset values
        apply_reset();
        chk_reset_values();

        // ---- CP0 only, completion at cycle 5
        drive_req(1'b0, 16'h0012, 64'hA5);               // cycle 0
        tick();                                           // cycle 1
        chk("c0_sel_c1",   128'(biu_csr_sel), 128'd1);
        chk("c0_op",       128'(biu_csr_op), 128'h0012);
        chk("c0_wdata",    128'(biu_csr_wdata), 128'hA5);
        chk("c0_busy",     128'(biu_csr_busy), 128'd1);
        chk("c0_state_b",  128'(o_dbg_state), 128'd1);
        tick();                                           // cycle 2
        cp0_biu_csr_op    = 16'hFFFF;                     // ignored after grant
        cp0_biu_csr_wdata = 64'hDEAD;
        tick();                                           // cycle 3
        chk("c0_op_hold",  128'(biu_csr_op), 128'h0012);
        chk("c0_wd_hold",  128'(biu_csr_wdata), 128'hA5);
        tick();                                           // cycle 4
        tick();                                           // cycle 5
        chk("c0_sel_c5",   128'(biu_csr_sel), 128'd1);
        chk("c0_nocmp_c5", 128'(biu_cp0_csr_cmplt), 128'd0);
        biu_csr_cmplt = 1'b1;
        biu_csr_rdata = 128'h1234;
        tick();                                           // cycle 6
        biu_csr_cmplt = 1'b0;
        chk("c0_cmplt",    128'(biu_cp0_csr_cmplt), 128'd1);
        chk("c0_rdata",    biu_cp0_csr_rdata, 128'h1234);
        chk("c0_err",      128'(biu_cp0_csr_err), 128'd0);
        chk("c0_no_had",   128'(biu_had_csr_cmplt), 128'd0);
        chk("c0_sel_c6",   128'(biu_csr_sel), 128'd0);
        chk("c0_busy_d",   128'(biu_csr_busy), 128'd1);
        chk("c0_state_d",  128'(o_dbg_state), 128'd2);
        cp0_biu_csr_req = 1'b0;
        tick();                                           // cycle 7
        chk("c0_pulse1",   128'(biu_cp0_csr_cmplt), 128'd0);
        chk("c0_rd_held",  biu_cp0_csr_rdata, 128'h1234);
        chk("c0_idle_bsy", 128'(biu_csr_busy), 128'd0);

        // ---- Tie after reset: CP0, then HAD, then CP0 again
        apply_reset();
        drive_req(1'b0, 16'h0C01, 64'h11);
        drive_req(1'b1, 16'h0D01, 64'h22);
        tick();                                           // c1
        chk("tie1_op",     128'(biu_csr_op), 128'h0C01);
        chk("tie1_wd",     128'(biu_csr_wdata), 128'h11);
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hC0;
        tick();                                           // c2 DONE
        biu_csr_cmplt = 1'b0;
        chk("tie1_cp0",    128'(biu_cp0_csr_cmplt), 128'd1);
        chk("tie1_nohad",  128'(biu_had_csr_cmplt), 128'd0);
        cp0_biu_csr_req = 1'b0;
        tick();                                           // c3 IDLE
        chk("tie_gap",     128'(biu_csr_sel), 128'd0);
        tick();                                           // c4 BUSY (HAD)
        chk("tie2_sel",    128'(biu_csr_sel), 128'd1);
        chk("tie2_op",     128'(biu_csr_op), 128'h0D01);
        chk("tie2_wd",     128'(biu_csr_wdata), 128'h22);
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hD0;
        tick();                                           // c5 DONE
        biu_csr_cmplt = 1'b0;
        chk("tie2_had",    128'(biu_had_csr_cmplt), 128'd1);
        chk("tie2_hrd",    biu_had_csr_rdata, 128'hD0);
        chk("tie2_crd",    biu_cp0_csr_rdata, 128'hC0);
        had_biu_csr_req = 1'b0;
        tick();                                           // c6 IDLE
        drive_req(1'b0, 16'h0C02, 64'h33);
        drive_req(1'b1, 16'h0D02, 64'h44);
        tick();                                           // c7 BUSY (CP0)
        chk("tie3_op",     128'(biu_csr_op), 128'h0C02);
        cp0_biu_csr_req = 1'b0;                           // withdrawn mid-BUSY
        tick();                                           // c8
        chk("wdr_sel",     128'(biu_csr_sel), 128'd1);
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hC1;
        tick();                                           // c9 DONE
        biu_csr_cmplt = 1'b0;
        chk("wdr_cmplt",   128'(biu_cp0_csr_cmplt), 128'd1);
        chk("wdr_rdata",   biu_cp0_csr_rdata, 128'hC1);
        tick();                                           // c10 IDLE
        tick();                                           // c11 BUSY (HAD)
        chk("tie4_op",     128'(biu_csr_op), 128'h0D02);
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hD1;
        tick();
        biu_csr_cmplt = 1'b0;
        chk("tie4_had",    128'(biu_had_csr_cmplt), 128'd1);
        had_biu_csr_req = 1'b0;
        tick();                                           // IDLE

        // ---- Randomized traffic against the transaction model
        ref_last  = 1'b1;
        ref_rd[0] = 128'hC1;
        ref_rd[1] = 128'hD1;
        for (int it = 0; it < 40; it++) begin
            int mode;
            mode = $urandom_range(1, 3);
            pend[0] = mode[0];
            pend[1] = mode[1];
            for (int r = 0; r < 2; r++) begin
                ref_op[r] = 16'($urandom);
                ref_wd[r] = {$urandom, $urandom};
                if (pend[r]) drive_req(r[0], ref_op[r], ref_wd[r]);
            end
            while (pend[0] || pend[1]) begin
                win = (pend[0] && pend[1]) ? ~ref_last : pend[1];
                biu_csr_cmplt = 1'($urandom_range(0, 1));  // spurious in IDLE
                tick();
                biu_csr_cmplt = 1'b0;
                chk("rnd_sel",     128'(biu_csr_sel), 128'd1);
                chk("rnd_op",      128'(biu_csr_op), 128'(ref_op[win]));
                chk("rnd_wd",      128'(biu_csr_wdata), 128'(ref_wd[win]));
                chk("rnd_spur",    128'({biu_cp0_csr_cmplt, biu_had_csr_cmplt}), 128'd0);
                lat = $urandom_range(0, 3);
                for (int k = 0; k < lat; k++) begin
                    tick();
                    chk("rnd_sel_hold", 128'(biu_csr_sel), 128'd1);
                end
                rd = {$urandom, $urandom, $urandom, $urandom};
                biu_csr_rdata = rd;
                biu_csr_cmplt = 1'b1;
                tick();
                biu_csr_cmplt = 1'b0;
                chk("rnd_win_cmplt", 128'(win ? biu_had_csr_cmplt : biu_cp0_csr_cmplt), 128'd1);
                chk("rnd_oth_cmplt", 128'(win ? biu_cp0_csr_cmplt : biu_had_csr_cmplt), 128'd0);
                chk("rnd_win_rdata", win ? biu_had_csr_rdata : biu_cp0_csr_rdata, rd);
                chk("rnd_win_err",   128'(win ? biu_had_csr_err : biu_cp0_csr_err), 128'd0);
                chk("rnd_done_sel",  128'(biu_csr_sel), 128'd0);
                if (win) had_biu_csr_req = 1'b0; else cp0_biu_csr_req = 1'b0;
                pend[win]   = 1'b0;
                ref_last    = win;
                ref_rd[win] = rd;
                tick();
                chk("rnd_idle_sel",  128'(biu_csr_sel), 128'd0);
                chk("rnd_idle_busy", 128'(biu_csr_busy), 128'd0);
                chk("rnd_oth_rdata", win ? biu_cp0_csr_rdata : biu_had_csr_rdata, ref_rd[~win]);
            end
        end

        // ---- Reset during BUSY
        drive_req(1'b0, 16'h0E01, 64'h55);
        tick();
        tick();
        chk("mid_busy_pre", 128'(biu_csr_busy), 128'd1);
        cpurst_b        = 1'b0;
        cp0_biu_csr_req = 1'b0;
        tick();
        chk_reset_values();
        cpurst_b = 1'b1;
        tick();
        tick();
        chk("mid_no_cmplt", 128'({biu_cp0_csr_cmplt, biu_had_csr_cmplt}), 128'd0);
        drive_req(1'b1, 16'h0F01, 64'h66);
        tick();
        chk("post_rst_op",  128'(biu_csr_op), 128'h0F01);
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hF1;
        tick();
        biu_csr_cmplt = 1'b0;
        chk("post_rst_had", 128'(biu_had_csr_cmplt), 128'd1);
        chk("post_rst_rd",  biu_had_csr_rdata, 128'hF1);
        had_biu_csr_req = 1'b0;
        tick();

`ifdef CT_BIU_CSR_TIMEOUT_EN
        // ---- Timeout after 8 BUSY cycles; late completion discarded
        apply_reset();
        drive_req(1'b0, 16'h0101, 64'h77);               // cycle 0
        tick();
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hBEEF;
        tick();
        biu_csr_cmplt = 1'b0;
        chk("to_pre_rd",    biu_cp0_csr_rdata, 128'hBEEF);
        cp0_biu_csr_req = 1'b0;
        tick();
        drive_req(1'b0, 16'h0102, 64'h88);               // cycle 0
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("to_sel",   128'(biu_csr_sel), 128'd1);
        end
        chk("to_sticky_pre", 128'(biu_csr_timeout_sticky), 128'd0);
        tick();                                           // cycle 9
        chk("to_cmplt",     128'(biu_cp0_csr_cmplt), 128'd1);
        chk("to_err",       128'(biu_cp0_csr_err), 128'd1);
        chk("to_rdata",     biu_cp0_csr_rdata, 128'd0);
        chk("to_sticky",    128'(biu_csr_timeout_sticky), 128'd1);
        cp0_biu_csr_req = 1'b0;
        tick();                                           // cycle 10
        tick();                                           // cycle 11
        tick();                                           // cycle 12
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hDEAD;
        tick();                                           // cycle 13
        biu_csr_cmplt = 1'b0;
        chk("late_cmplt",   128'({biu_cp0_csr_cmplt, biu_had_csr_cmplt}), 128'd0);
        chk("late_rdata",   biu_cp0_csr_rdata, 128'd0);
        chk("late_sticky",  128'(biu_csr_timeout_sticky), 128'd1);

        // ---- Completion in the expiry cycle wins
        apply_reset();
        drive_req(1'b1, 16'h0201, 64'h99);               // cycle 0
        for (int c = 1; c <= 8; c++) tick();
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'hCAFE;  // cycle 8
        tick();                                           // cycle 9
        biu_csr_cmplt = 1'b0;
        chk("race_cmplt",   128'(biu_had_csr_cmplt), 128'd1);
        chk("race_err",     128'(biu_had_csr_err), 128'd0);
        chk("race_rdata",   biu_had_csr_rdata, 128'hCAFE);
        chk("race_sticky",  128'(biu_csr_timeout_sticky), 128'd0);
        had_biu_csr_req = 1'b0;
        tick();
`else
        // ---- No timeout: completion withheld for 5000 cycles
        apply_reset();
        drive_req(1'b0, 16'h0301, 64'hAA);               // cycle 0
        sel_low = 0;
        for (int c = 1; c <= 5000; c++) begin
            tick();
            if (biu_csr_sel !== 1'b1 || biu_cp0_csr_cmplt !== 1'b0) sel_low++;
        end
        chk("nto_sel_held", 128'(sel_low), 128'd0);
        chk("nto_sticky",   128'(biu_csr_timeout_sticky), 128'd0);
        biu_csr_cmplt = 1'b1; biu_csr_rdata = 128'h5000;  // cycle 5000
        tick();
        biu_csr_cmplt = 1'b0;
        chk("nto_cmplt",    128'(biu_cp0_csr_cmplt), 128'd1);
        chk("nto_rdata",    biu_cp0_csr_rdata, 128'h5000);
        chk("nto_err",      128'(biu_cp0_csr_err), 128'd0);
        chk("nto_sticky2",  128'(biu_csr_timeout_sticky), 128'd0);
        cp0_biu_csr_req = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
